// File: rtl/branch_predictor_bht.sv
// Two-bit saturating-counter branch history table: zero-latency lookup on the
// fetch PC, training from the resolved branch, plus saturating debug counters.
module branch_predictor_bht #(
  parameter int unsigned IDX_W      = 6,
  parameter logic [1:0]  INIT_STATE = 2'b01,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [31:0]      pc_i,
  output logic             pred_taken_o,
  output logic [1:0]       pred_state_o,
  input  logic             update_en_i,
  input  logic [31:0]      update_pc_i,
  input  logic             update_taken_i,
  input  logic             update_pred_i,
  output logic             mispredict_o,
  output logic [CNT_W-1:0] branch_cnt_o,
  output logic [CNT_W-1:0] miss_cnt_o
);

  localparam int unsigned DEPTH = 2 ** IDX_W;

  typedef enum logic [1:0] {
    ST_SNT = 2'b00,
    ST_WNT = 2'b01,
    ST_WT  = 2'b10,
    ST_ST  = 2'b11
  } bht_state_e;

  bht_state_e       tbl_q [DEPTH];
  logic [IDX_W-1:0] idx_r;
  logic [IDX_W-1:0] idx_u;
  bht_state_e       cur_u;
  bht_state_e       nxt_u;
  logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
  logic [CNT_W-1:0] miss_cnt_q, miss_cnt_d;
  logic             unused_pc_bits;

  assign idx_r = pc_i[IDX_W+1:2];
  assign idx_u = update_pc_i[IDX_W+1:2];

  // No bypass: a same-cycle update to idx_r shows up only after the edge.
  assign pred_state_o = tbl_q[idx_r];
  assign pred_taken_o = pred_state_o[1];

  assign mispredict_o = update_en_i & (update_taken_i != update_pred_i);

  assign unused_pc_bits = ^{pc_i[31:IDX_W+2], pc_i[1:0],
                            update_pc_i[31:IDX_W+2], update_pc_i[1:0]};

  always_comb begin
    cur_u = tbl_q[idx_u];
    nxt_u = cur_u;
    unique case (cur_u)
      ST_SNT: nxt_u = update_taken_i ? ST_WNT : ST_SNT;
      ST_WNT: nxt_u = update_taken_i ? ST_WT  : ST_SNT;
      ST_WT:  nxt_u = update_taken_i ? ST_ST  : ST_WNT;
      ST_ST:  nxt_u = update_taken_i ? ST_ST  : ST_WT;
    endcase
  end

  always_comb begin
    branch_cnt_d = branch_cnt_q;
    miss_cnt_d   = miss_cnt_q;
    if (update_en_i && (branch_cnt_q != '1)) begin
      branch_cnt_d = branch_cnt_q + 1'b1;
    end
    if (mispredict_o && (miss_cnt_q != '1)) begin
      miss_cnt_d = miss_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        tbl_q[IDX_W'(i)] <= bht_state_e'(INIT_STATE);
      end
      branch_cnt_q <= '0;
      miss_cnt_q   <= '0;
    end else begin
      if (update_en_i) begin
        tbl_q[idx_u] <= nxt_u;
      end
      branch_cnt_q <= branch_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
    end
  end

  assign branch_cnt_o = branch_cnt_q;
  assign miss_cnt_o   = miss_cnt_q;

endmodule

// File: tb/tb_branch_predictor_bht.sv
// Scoreboard bench for branch_predictor_bht: directed scenarios then random
// traffic, checked against an integer-arithmetic model of the table.
module tb_branch_predictor_bht;

  localparam int unsigned IDX_W = 6;
  localparam int unsigned CNT_W = 3;
  localparam int unsigned DEPTH = 64;
  localparam int          CMAX  = 7;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic [31:0]      pc_i;
  logic             pred_taken_o;
  logic [1:0]       pred_state_o;
  logic             update_en_i;
  logic [31:0]      update_pc_i;
  logic             update_taken_i;
  logic             update_pred_i;
  logic             mispredict_o;
  logic [CNT_W-1:0] branch_cnt_o;
  logic [CNT_W-1:0] miss_cnt_o;

  branch_predictor_bht #(
    .IDX_W(IDX_W),
    .INIT_STATE(2'b01),
    .CNT_W(CNT_W)
  ) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .pc_i(pc_i),
    .pred_taken_o(pred_taken_o),
    .pred_state_o(pred_state_o),
    .update_en_i(update_en_i),
    .update_pc_i(update_pc_i),
    .update_taken_i(update_taken_i),
    .update_pred_i(update_pred_i),
    .mispredict_o(mispredict_o),
    .branch_cnt_o(branch_cnt_o),
    .miss_cnt_o(miss_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int st;
    bit mis;
    int bc;
    int mc;
  } exp_t;

  exp_t exp_q[$];
  int   model_tbl[DEPTH];
  int   m_bc;
  int   m_mc;
  int   n_pass  = 0;
  int   n_total = 0;

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc / 4) % DEPTH);
  endfunction

  task automatic check(input string name, input int got, input int want);
    n_total++;
    if (got == want) n_pass++;
    else $display("FAIL %s got=%0d expected=%0d", name, got, want);
  endtask

  // Monitor: outputs are combinational/registered every cycle, so one entry per cycle.
  always @(negedge clk_i) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("pred_state", int'(pred_state_o), e.st);
      check("pred_taken", int'(pred_taken_o), (e.st >= 2) ? 1 : 0);
      check("mispredict", int'(mispredict_o), int'(e.mis));
      check("branch_cnt", int'(branch_cnt_o), e.bc);
      check("miss_cnt",   int'(miss_cnt_o),   e.mc);
    end
  end

  task automatic cycle(input bit chk, input logic rst, input logic [31:0] pc,
                       input logic en, input logic [31:0] upc,
                       input logic tk, input logic pr);
    exp_t e;
    rst_i          = rst;
    pc_i           = pc;
    update_en_i    = en;
    update_pc_i    = en ? upc : 32'hxxxx_xxxx;
    update_taken_i = tk;
    update_pred_i  = pr;
    if (chk) begin
      e.st  = model_tbl[idx_of(pc)];
      e.mis = en && (tk != pr);
      e.bc  = m_bc;
      e.mc  = m_mc;
      exp_q.push_back(e);
    end
    @(posedge clk_i);
    if (rst) begin
      foreach (model_tbl[i]) model_tbl[i] = 1;
      m_bc = 0;
      m_mc = 0;
    end else if (en) begin
      model_tbl[idx_of(upc)] = tk ? ((model_tbl[idx_of(upc)] + 1 > 3) ? 3 : model_tbl[idx_of(upc)] + 1)
                                  : ((model_tbl[idx_of(upc)] - 1 < 0) ? 0 : model_tbl[idx_of(upc)] - 1);
      if (m_bc < CMAX) m_bc++;
      if (tk != pr && m_mc < CMAX) m_mc++;
    end
    #1;
  endtask

  initial begin
    #1;
    // Reset held for two edges; DUT state before reset is unknown, so unchecked.
    cycle(1'b0, 1'b1, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);

    for (int i = 0; i < 64; i++)
      cycle(1'b1, 1'b0, 32'(i * 4), 1'b0, 32'h0, 1'b0, 1'b0);

    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 32'h40, 1'b1, 32'h40, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) cycle(1'b1, 1'b0, 32'h40, 1'b1, 32'h40, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 32'h40, 1'b0, 32'h0, 1'b0, 1'b0);

    cycle(1'b1, 1'b0, 32'h80, 1'b1, 32'h80, 1'b1, 1'b1);
    cycle(1'b1, 1'b0, 32'h80, 1'b0, 32'h0, 1'b0, 1'b0);

    cycle(1'b1, 1'b0, 32'h004, 1'b1, 32'h104, 1'b1, 1'b1);
    cycle(1'b1, 1'b0, 32'h004, 1'b0, 32'h0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 32'h008, 1'b0, 32'h0, 1'b0, 1'b0);

    cycle(1'b1, 1'b1, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 32'h10, 1'b1, 32'h10, 1'b1, 1'b0);
    cycle(1'b1, 1'b0, 32'h10, 1'b1, 32'h10, 1'b1, 1'b1);
    cycle(1'b1, 1'b0, 32'h10, 1'b1, 32'h10, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 32'h10, 1'b1, 32'h10, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 32'h10, 1'b0, 32'h0, 1'b0, 1'b0);

    cycle(1'b1, 1'b1, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) cycle(1'b1, 1'b0, 32'h20, 1'b1, 32'h20, 1'b1, 1'b0);
    cycle(1'b1, 1'b0, 32'h20, 1'b0, 32'h0, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 32'h20, 1'b1, 32'h20, 1'b1, 1'b0);
    cycle(1'b1, 1'b0, 32'h20, 1'b0, 32'h0, 1'b0, 1'b0);

    for (int i = 0; i < 2000; i++) begin
      logic [31:0] upc, pc;
      upc = {$urandom_range(0, 3) == 0 ? $urandom : 32'h0, 24'h0} |
            32'({$urandom_range(0, 15), 2'($urandom)});
      pc  = ($urandom_range(0, 3) == 0) ? upc : 32'({$urandom_range(0, 15), 2'($urandom)});
      cycle(1'b1, ($urandom_range(0, 63) == 0), pc, 1'($urandom), upc,
            1'($urandom), 1'($urandom));
    end

    rst_i       = 1'b0;
    update_en_i = 1'b0;
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk_i);
    @(posedge clk_i);
    if (exp_q.size() != 0) begin
      n_total++;
      $display("FAIL drain pending=%0d expected=0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
